icache_axi_rd: RTL and testbench

ICACHE_AXI_RD -- requirements
Module: icache_axi_rd

---
 rtl/icache_axi_rd_pkg.sv | 22 ++
 rtl/icache_axi_rd.sv | 112 +++++++++++
 tb/tb_icache_axi_rd.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_rd_pkg.sv
// Shared definitions for the instruction-cache AXI4 single-beat refill reader.
// FSM state encodings (one-hot) and the fixed AXI read-address attributes.
`timescale 1ns/1ps
package icache_axi_rd_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_AR   = 4'b0010,
    ST_R    = 4'b0100,
    ST_HOLD = 4'b1000
  } state_t;

  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/icache_axi_rd.sv
// Instruction-cache miss refill: one outstanding single-beat AXI4 read per miss.
// Optional macro ICACHE_RD_ERR_EN adds the cache_rd_err output (rresp != OKAY).
`timescale 1ns/1ps
module icache_axi_rd
  import icache_axi_rd_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_read_ena,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_read_resp,
  output logic [DATA_W-1:0] cache_in_data,
  output logic              cache_in_valid,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic [ID_W-1:0]   rid,
  input  logic              rlast
`ifdef ICACHE_RD_ERR_EN
  ,
  output logic              cache_rd_err
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;

  // Single-beat reads: rlast carries no information; low address bits are dropped on alignment.
`ifdef ICACHE_RD_ERR_EN
  logic unused_inputs;
  assign unused_inputs = ^{rlast, cache_addr[2:0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{rlast, rresp, cache_addr[2:0]};
`endif

  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign arlen   = LEN_SINGLE;
  assign arsize  = SIZE_8B;
  assign arburst = BURST_INCR;

  // FSM with registered handshake and refill outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      cache_in_valid <= 1'b0;
      cache_in_data  <= '0;
`ifdef ICACHE_RD_ERR_EN
      cache_rd_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cache_read_ena) begin
            addr_q  <= {cache_addr[ADDR_W-1:3], 3'b000};
            arvalid <= 1'b1;
            state   <= ST_AR;
          end
        end
        ST_AR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          // Beats tagged with a foreign ID are drained and dropped.
          if (rvalid && (rid == AXI_ID)) begin
            rready         <= 1'b0;
            cache_in_valid <= 1'b1;
            cache_in_data  <= rdata;
`ifdef ICACHE_RD_ERR_EN
            cache_rd_err   <= (rresp != RESP_OKAY);
`endif
            state          <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cache_read_resp) begin
            cache_in_valid <= 1'b0;
`ifdef ICACHE_RD_ERR_EN
            cache_rd_err   <= 1'b0;
`endif
            state          <= ST_IDLE;
          end
        end
        default: begin
          state          <= ST_IDLE;
          arvalid        <= 1'b0;
          rready         <= 1'b0;
          cache_in_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_rd.sv
// Randomized scoreboard bench for icache_axi_rd: driver pushes expected refills,
// a negedge monitor pops and compares on each AR handshake and refill delivery.
`timescale 1ns/1ps
module tb_icache_axi_rd;

  logic        clk;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic        cache_read_resp;
  logic [63:0] cache_in_data;
  logic        cache_in_valid;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
`ifdef ICACHE_RD_ERR_EN
  logic        cache_rd_err;
`endif

  icache_axi_rd dut (
    .clk             (clk),
    .rst             (rst),
    .cache_read_ena  (cache_read_ena),
    .cache_addr      (cache_addr),
    .cache_read_resp (cache_read_resp),
    .cache_in_data   (cache_in_data),
    .cache_in_valid  (cache_in_valid),
    .arvalid         (arvalid),
    .arready         (arready),
    .araddr          (araddr),
    .arid            (arid),
    .arlen           (arlen),
    .arsize          (arsize),
    .arburst         (arburst),
    .rvalid          (rvalid),
    .rready          (rready),
    .rdata           (rdata),
    .rresp           (rresp),
    .rid             (rid),
    .rlast           (rlast)
`ifdef ICACHE_RD_ERR_EN
    ,
    .cache_rd_err    (cache_rd_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic        exp_err_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: protocol invariants plus scoreboard pops.
  logic        prev_valid, prev_arvalid;
  logic [63:0] prev_data, prev_araddr;

  always @(negedge clk) begin
    if (!rst) begin
      prev_valid   <= 1'b0;
      prev_arvalid <= 1'b0;
      prev_data    <= '0;
      prev_araddr  <= '0;
    end else begin
      if (arvalid) begin
        chk("ar_attrs", 64'({arid, arlen, arsize, arburst}), 64'({4'd0, 8'd0, 3'b011, 2'b01}));
        chk("no_rready_with_arvalid", 64'(rready), 64'd0);
      end
      if (arvalid && prev_arvalid)
        chk("araddr_stable", araddr, prev_araddr);
      if (arvalid && arready) begin
        if (exp_addr_q.size() == 0) chk("araddr_unexpected_hs", 64'd1, 64'd0);
        else chk("araddr", araddr, exp_addr_q.pop_front());
      end
      if (cache_in_valid && !prev_valid) begin
        if (exp_data_q.size() == 0) chk("refill_unexpected", 64'd1, 64'd0);
        else begin
          chk("refill_data", cache_in_data, exp_data_q.pop_front());
`ifdef ICACHE_RD_ERR_EN
          chk("rd_err", 64'(cache_rd_err), 64'(exp_err_q.pop_front()));
`else
          void'(exp_err_q.pop_front());
`endif
        end
      end
      if (cache_in_valid && prev_valid)
        chk("refill_data_stable", cache_in_data, prev_data);
`ifdef ICACHE_RD_ERR_EN
      if (!cache_in_valid) chk("rd_err_idle", 64'(cache_rd_err), 64'd0);
`endif
      prev_valid   <= cache_in_valid;
      prev_arvalid <= arvalid;
      prev_data    <= cache_in_data;
      prev_araddr  <= araddr;
    end
  end

  task automatic chk_reset_outputs(input string name);
    chk(name, 64'({arvalid, rready, cache_in_valid}), 64'd0);
    chk({name, "_data"}, cache_in_data, 64'd0);
    chk({name, "_addr"}, araddr, 64'd0);
`ifdef ICACHE_RD_ERR_EN
    chk({name, "_err"}, 64'(cache_rd_err), 64'd0);
`endif
  endtask

  // One miss: AR stall, foreign-ID beats, refill beat, delayed cache ack; optional reset in R.
  task automatic run_txn(input logic [63:0] addr, input logic [63:0] data,
                         input int ar_dly, input int n_bad, input int resp_dly,
                         input logic [1:0] resp, input bit drop_ena, input bit abort_in_r);
    exp_addr_q.push_back({addr[63:3], 3'b000});
    exp_data_q.push_back(data);
    exp_err_q.push_back(resp != 2'b00);
    cache_read_ena = 1'b1;
    cache_addr     = addr;
    tick();
    chk("arvalid_latency", 64'(arvalid), 64'd1);
    if (drop_ena) cache_read_ena = 1'b0;
    for (int i = 0; i < ar_dly; i++) begin
      arready = 1'b0;
      tick();
      chk("ar_stall_rready", 64'(rready), 64'd0);
      chk("ar_stall_arvalid", 64'(arvalid), 64'd1);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rready_after_hs", 64'({arvalid, rready}), 64'b01);
    if (abort_in_r) begin
      rst = 1'b0;
      cache_read_ena = 1'b0;
      tick();
      chk_reset_outputs("reset_in_r");
      rst = 1'b1;
      void'(exp_data_q.pop_back());
      void'(exp_err_q.pop_back());
      return;
    end
    for (int i = 0; i < n_bad; i++) begin
      rvalid = 1'b1;
      rid    = 4'($urandom_range(1, 15));
      rdata  = {$urandom, $urandom};
      rresp  = 2'($urandom);
      tick();
      chk("foreign_beat_dropped", 64'({cache_in_valid, rready}), 64'b01);
    end
    rvalid = 1'b1;
    rid    = 4'd0;
    rdata  = data;
    rresp  = resp;
    tick();
    rvalid = 1'b0;
    rdata  = {$urandom, $urandom};
    chk("refill_latency", 64'({cache_in_valid, rready}), 64'b10);
    for (int i = 0; i < resp_dly; i++) begin
      cache_read_ena = 1'($urandom);
      tick();
      chk("hold_valid", 64'(cache_in_valid), 64'd1);
    end
    cache_read_resp = 1'b1;
    cache_read_ena  = 1'b0;
    tick();
    cache_read_resp = 1'b0;
    chk("valid_drop", 64'({cache_in_valid, arvalid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cache_read_ena = 1'b0;
    cache_addr = '0;
    cache_read_resp = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    rid = 4'd0;
    rlast = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Minimum-latency refill with the reference values.
    run_txn(64'h8000_0014, 64'h0000_0013_0000_0093, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    // AR stall of five cycles.
    run_txn(64'h0000_1234_5678_9ABF, 64'h1111_2222_3333_4444, 5, 0, 0, 2'b00, 1'b0, 1'b0);
    // Cache ack delayed four cycles.
    run_txn(64'h0000_0000_0000_0008, 64'h5555_AAAA_5555_AAAA, 0, 0, 4, 2'b00, 1'b0, 1'b0);
    // Foreign-ID beat then the real one.
    run_txn(64'h0000_0000_0000_0040, 64'h0000_0000_DEAD_BEEF, 0, 1, 0, 2'b00, 1'b1, 1'b0);
    // Error response, then OKAY.
    run_txn(64'h0000_0000_0000_0100, 64'hFFFF_0000_FFFF_0000, 1, 0, 1, 2'b10, 1'b0, 1'b0);
    run_txn(64'h0000_0000_0000_0108, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    // Reset while waiting in R, then a fresh request.
    run_txn(64'h0000_0000_0000_0200, 64'h0, 2, 0, 0, 2'b00, 1'b0, 1'b1);
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 2'b00, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_txn({$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom),
              ($urandom_range(0, 9) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    tick();
    chk("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);
    chk("data_queue_drained", 64'(exp_data_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
